// File: rtl/ni_tx_if.sv
// ni_tx_if: signal bundle of the NI transmitter.
// master: the transmitter side (takes commands/payload and router status, drives flits and status).
// slave : the core plus router side.
// Signals: cmd_* packet command handshake, pl_* payload stream handshake,
//          odata/ovalid/ovch flit channel, irdy/ilck/iack per-VC router status,
//          busy and pkt_cnt transmitter status.
interface ni_tx_if #(
  parameter int DATA_W  = 32,
  parameter int NVC     = 3,
  parameter int VCW     = 2,
  parameter int COORD_W = 2,
  parameter int LEN_W   = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_dstx;
  logic [COORD_W-1:0] cmd_dsty;
  logic [LEN_W-1:0]   cmd_len;
  logic [VCW-1:0]     cmd_vch;
  logic               pl_valid;
  logic [DATA_W-3:0]  pl_data;
  logic               pl_ready;
  logic [DATA_W-1:0]  odata;
  logic               ovalid;
  logic [VCW-1:0]     ovch;
  logic [NVC-1:0]     irdy;
  logic [NVC-1:0]     ilck;
  logic [NVC-1:0]     iack;
  logic               busy;
  logic [15:0]        pkt_cnt;
  modport master (
    input  cmd_valid, cmd_dstx, cmd_dsty, cmd_len, cmd_vch, pl_valid, pl_data, irdy, ilck, iack,
    output cmd_ready, pl_ready, odata, ovalid, ovch, busy, pkt_cnt
  );
  modport slave (
    output cmd_valid, cmd_dstx, cmd_dsty, cmd_len, cmd_vch, pl_valid, pl_data, irdy, ilck, iack,
    input  cmd_ready, pl_ready, odata, ovalid, ovch, busy, pkt_cnt
  );
endinterface

// File: rtl/ni_tx.sv
// ni_tx: injection-side NI transmitter turning a packet command plus payload stream into router flits.
// Ports: clk; rst_ (synchronous, active-low); bus (ni_tx_if.master) carrying the command and
//        payload handshakes, the registered flit channel odata/ovalid/ovch, the per-VC router
//        status irdy/ilck/iack, and the busy/pkt_cnt status outputs.
// Optional: define NI_TX_CREDIT_EN to pace each VC with local credit counters instead of irdy.
module ni_tx #(
  parameter int DATA_W    = 32,
  parameter int NVC       = 3,
  parameter int VCW       = 2,
  parameter int COORD_W   = 2,
  parameter int LEN_W     = 4,
  parameter int MY_XPOS   = 0,
  parameter int MY_YPOS   = 0,
  parameter int CRED_INIT = 4
) (
  input logic    clk,
  input logic    rst_,
  ni_tx_if.master bus
);
  localparam int PAD = DATA_W - 2 - 4 * COORD_W - LEN_W;
  localparam logic [1:0] F_BODY = 2'b00, F_HEAD = 2'b01, F_TAIL = 2'b10, F_HT = 2'b11;
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
  state_t             st;
  logic [COORD_W-1:0] dx_q, dy_q;
  logic [LEN_W-1:0]   len_q, rem;
  logic [VCW-1:0]     vc_q;
  logic               can_send, can_head, pl_hs, last;
  logic [DATA_W-1:0]  head;
  assign can_head    = can_send && !bus.ilck[vc_q];
  assign bus.pl_ready = st == BODY && can_send;
  assign pl_hs       = bus.pl_valid && bus.pl_ready;
  assign last        = rem == LEN_W'(1);
  assign head        = {len_q == '0 ? F_HT : F_HEAD, dx_q, dy_q, COORD_W'(MY_XPOS), COORD_W'(MY_YPOS),
                        len_q, {PAD{1'b0}}};
`ifdef NI_TX_CREDIT_EN
  localparam int CW = $clog2(CRED_INIT + 1);
  logic [CW-1:0] cred [NVC];
  logic          snd;
  logic          unused;
  assign unused   = ^bus.irdy;
  assign snd      = (st == HEAD && can_head) || pl_hs;
  assign can_send = cred[vc_q] != '0;
  // a send and an ack in the same cycle cancel; acks never push a credit above CRED_INIT
  always_ff @(posedge clk)
    for (int i = 0; i < NVC; i++)
      if (!rst_) cred[i] <= CW'(CRED_INIT);
      else if (snd && vc_q == VCW'(i)) cred[i] <= bus.iack[i] ? cred[i] : cred[i] - CW'(1);
      else if (bus.iack[i] && cred[i] != CW'(CRED_INIT)) cred[i] <= cred[i] + CW'(1);
`else
  logic unused;
  assign unused   = ^{bus.iack, CRED_INIT != 0};
  assign can_send = bus.irdy[vc_q];
`endif
  always_ff @(posedge clk)
    if (!rst_) begin
      st            <= IDLE;
      bus.cmd_ready <= 1'b0;
      bus.odata     <= '0;
      bus.ovalid    <= 1'b0;
      bus.ovch      <= '0;
      bus.busy      <= 1'b0;
      bus.pkt_cnt   <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      len_q         <= '0;
      rem           <= '0;
      vc_q          <= '0;
    end else begin
      bus.ovalid <= 1'b0;
      bus.odata  <= '0;
      case (st)
        IDLE:
          if (bus.cmd_valid && bus.cmd_ready) begin
            dx_q          <= bus.cmd_dstx;
            dy_q          <= bus.cmd_dsty;
            len_q         <= bus.cmd_len;
            rem           <= bus.cmd_len;
            vc_q          <= int'(bus.cmd_vch) < NVC ? bus.cmd_vch : '0;
            st            <= HEAD;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end else bus.cmd_ready <= 1'b1;
        HEAD:
          if (can_head) begin
            bus.ovalid <= 1'b1;
            bus.ovch   <= vc_q;
            bus.odata  <= head;
            if (len_q == '0) begin
              bus.pkt_cnt   <= bus.pkt_cnt + 16'd1;
              bus.cmd_ready <= 1'b1;
              bus.busy      <= 1'b0;
              st            <= IDLE;
            end else st <= BODY;
          end
        BODY:
          if (pl_hs) begin
            bus.ovalid <= 1'b1;
            bus.ovch   <= vc_q;
            bus.odata  <= {last ? F_TAIL : F_BODY, bus.pl_data};
            rem        <= rem - LEN_W'(1);
            if (last) begin
              bus.pkt_cnt   <= bus.pkt_cnt + 16'd1;
              bus.cmd_ready <= 1'b1;
              bus.busy      <= 1'b0;
              st            <= IDLE;
            end
          end
        default: st <= IDLE;
      endcase
    end
endmodule
